// File: rtl/seg_scan_capture_if.sv
// Scan-bus capture interface.
//   seg_in      : segment lines gfedcba, 1 = lit
//   dig_sel     : one-hot digit select
//   digits_bcd  : captured code per digit, digit i in [4i+3:4i]
//   digit_err   : per-digit illegal-pattern flag from the last capture
//   frame_valid : every digit captured at least once since reset
//   update      : one-cycle capture pulse
//   update_idx  : digit written by the current update pulse
// master drives the scan bus, slave is the capture block.
interface seg_scan_capture_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic [4*NUM_DIGITS-1:0] digits_bcd;
  logic [NUM_DIGITS-1:0]   digit_err;
  logic                    frame_valid;
  logic                    update;
  logic [IDX_W-1:0]        update_idx;

  modport master (
    output seg_in, dig_sel,
    input  digits_bcd, digit_err, frame_valid, update, update_idx
  );

  modport slave (
    input  seg_in, dig_sel,
    output digits_bcd, digit_err, frame_valid, update, update_idx
  );
endinterface

// File: rtl/seg_scan_capture.sv
// Seven-segment scan-bus readback. Watches the multiplexed segment/select
// pair, waits until it has been stable for STABLE_CYCLES clocks, then
// decodes the segments back to a BCD code for the selected digit.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : seg_scan_capture_if slave (scan bus in, captured digits out)

// Per-digit capture register: code, error flag and "captured once" flag.
//   wr_i   : write strobe for this digit
//   code_i : decoded code to store
//   err_i  : decoded pattern was illegal
//   bcd_o / err_o / seen_o : stored state
module seg_scan_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_i,
  input  logic [3:0] code_i,
  input  logic       err_i,
  output logic [3:0] bcd_o,
  output logic       err_o,
  output logic       seen_o
);
  logic [3:0] bcd_q;
  logic       err_q;
  logic       seen_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q  <= 4'hF;
      err_q  <= 1'b0;
      seen_q <= 1'b0;
    end else if (wr_i) begin
      bcd_q  <= code_i;
      err_q  <= err_i;
      seen_q <= 1'b1;
    end
  end

  assign bcd_o  = bcd_q;
  assign err_o  = err_q;
  assign seen_o = seen_q;
endmodule

module seg_scan_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  seg_scan_capture_if.slave   bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  // Segment pattern (gfedcba) -> {err, code}. Dark digit reads as blank F.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b0111111: r = {1'b0, 4'h0};
      7'b0000110: r = {1'b0, 4'h1};
      7'b1011011: r = {1'b0, 4'h2};
      7'b1001111: r = {1'b0, 4'h3};
      7'b1100110: r = {1'b0, 4'h4};
      7'b1101101: r = {1'b0, 4'h5};
      7'b1111101: r = {1'b0, 4'h6};
      7'b0000111: r = {1'b0, 4'h7};
      7'b1111111: r = {1'b0, 4'h8};
      7'b1101111: r = {1'b0, 4'h9};
      7'b0000000: r = {1'b0, 4'hF};
      default:    r = {1'b1, 4'hE};
    endcase
    return r;
  endfunction

  // Held pair and stability counter
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  match;
  logic                  hit;
  logic                  sel_ok;
  logic                  cap;
  logic [NUM_DIGITS-1:0] wr;
  logic [IDX_W-1:0]      idx_d;
  logic [4:0]            dec;

  // Output-side registers
  logic                  update_q;
  logic [IDX_W-1:0]      update_idx_q;
  logic                  frame_valid_q;

  logic [NUM_DIGITS-1:0][3:0] bcd;
  logic [NUM_DIGITS-1:0]      err;
  logic [NUM_DIGITS-1:0]      seen;

  always_comb begin
    match = (bus.seg_in == seg_q) && (bus.dig_sel == sel_q);
    seg_d = seg_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    if (match) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      seg_d = bus.seg_in;
      sel_d = bus.dig_sel;
      cnt_d = CNT_W'(1);
    end
    // Capture only on the edge the count first reaches the target; a
    // saturated count on an unchanged pair must not fire again. A reload
    // to 1 counts as "reaching" it when STABLE_CYCLES is 1.
    hit    = (cnt_d == CNT_MAX) && (!match || (cnt_q != CNT_MAX));
    sel_ok = (sel_d != '0) && ((sel_d & (sel_d - NUM_DIGITS'(1))) == '0);
    cap    = hit && sel_ok;
    wr     = cap ? sel_d : '0;
    dec    = seg_decode(seg_d);
  end

  // One-hot to index; only meaningful when cap is set
  always_comb begin
    idx_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (sel_d[i]) idx_d = idx_d | IDX_W'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q         <= '0;
      sel_q         <= '0;
      cnt_q         <= '0;
      update_q      <= 1'b0;
      update_idx_q  <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      seg_q         <= seg_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      update_q      <= cap;
      if (cap) update_idx_q <= idx_d;
      frame_valid_q <= frame_valid_q | (&(seen | wr));
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
      seg_scan_digit u_dig (
        .clk    (clk),
        .rst    (rst),
        .wr_i   (wr[gi]),
        .code_i (dec[3:0]),
        .err_i  (dec[4]),
        .bcd_o  (bcd[gi]),
        .err_o  (err[gi]),
        .seen_o (seen[gi])
      );
    end
  endgenerate

  assign bus.digits_bcd  = bcd;
  assign bus.digit_err   = err;
  assign bus.frame_valid = frame_valid_q;
  assign bus.update      = update_q;
  assign bus.update_idx  = update_idx_q;
endmodule

// File: tb/tb_seg_scan_capture.sv
module tb_seg_scan_capture;
  localparam int N  = 4;
  localparam int SC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_capture_if #(.NUM_DIGITS(N)) bus ();

  seg_scan_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int upd_cnt = 0;

  logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                               7'b1111111, 7'b1101111};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: run length of identical samples; capture when run hits SC
  logic [3:0]   m_bcd [N];
  logic [N-1:0] m_err, m_seen;
  logic         m_fv, m_upd;
  logic [1:0]   m_idx;
  logic [6+N:0] m_prev;
  int           m_run;

  always @(posedge clk) begin
    logic [6+N:0] pair;
    logic [4*N-1:0] exp_bcd;
    int k;
    if (rst) begin
      for (int i = 0; i < N; i++) m_bcd[i] = 4'hF;
      m_err = '0; m_seen = '0; m_fv = 0; m_upd = 0; m_idx = '0;
      m_prev = '0; m_run = 0;
    end else begin
      pair = {bus.seg_in, bus.dig_sel};
      if (pair == m_prev) m_run++;
      else begin m_prev = pair; m_run = 1; end
      m_upd = 0;
      if (m_run == SC && $countones(bus.dig_sel) == 1) begin
        k = 0;
        for (int i = 0; i < N; i++) if (bus.dig_sel[i]) k = i;
        if (bus.seg_in == 7'b0) begin m_bcd[k] = 4'hF; m_err[k] = 0; end
        else begin
          m_bcd[k] = 4'hE; m_err[k] = 1;
          for (int v = 0; v < 10; v++)
            if (seg_tab[v] == bus.seg_in) begin m_bcd[k] = 4'(v); m_err[k] = 0; end
        end
        m_seen[k] = 1;
        if (&m_seen) m_fv = 1;
        m_upd = 1;
        m_idx = 2'(k);
      end
    end
    #1;
    for (int i = 0; i < N; i++) exp_bcd[4*i +: 4] = m_bcd[i];
    check("digits_bcd", 64'(bus.digits_bcd), 64'(exp_bcd));
    check("digit_err", 64'(bus.digit_err), 64'(m_err));
    check("frame_valid", 64'(bus.frame_valid), 64'(m_fv));
    check("update", 64'(bus.update), 64'(m_upd));
    check("update_idx", 64'(bus.update_idx), 64'(m_idx));
    if (bus.update === 1'b1) upd_cnt++;
  end

  // Apply a pair at the current negedge, keep it for n rising edges
  task automatic hold(input logic [6:0] s, input logic [N-1:0] d, input int n);
    bus.seg_in  = s;
    bus.dig_sel = d;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int u0;
    logic [6:0] s;
    logic [N-1:0] d;
    bus.seg_in = '0;
    bus.dig_sel = '0;
    repeat (3) @(negedge clk);
    check("rst_digits", 64'(bus.digits_bcd), 64'hFFFF);
    check("rst_err", 64'(bus.digit_err), 64'h0);
    check("rst_fv", 64'(bus.frame_valid), 64'h0);
    check("rst_upd", 64'(bus.update), 64'h0);
    rst = 1'b0;

    // Single capture, then long hold with no re-capture
    hold(7'b1011011, 4'b0010, 2);
    check("no_early_upd", 64'(bus.update), 64'h0);
    hold(7'b1011011, 4'b0010, 1);
    check("cap2_upd", 64'(bus.update), 64'h1);
    check("cap2_idx", 64'(bus.update_idx), 64'h1);
    check("cap2_val", 64'(bus.digits_bcd[7:4]), 64'h2);
    u0 = upd_cnt;
    hold(7'b1011011, 4'b0010, 10);
    check("no_recap", 64'(upd_cnt - u0), 64'h0);

    // Full scan
    hold(7'b0111111, 4'b0001, 3);
    hold(7'b0000110, 4'b0010, 3);
    hold(7'b1001111, 4'b0100, 3);
    check("fv_not_yet", 64'(bus.frame_valid), 64'h0);
    hold(7'b1100110, 4'b1000, 3);
    check("scan_digits", 64'(bus.digits_bcd), 64'h4310);
    check("scan_fv", 64'(bus.frame_valid), 64'h1);
    check("scan_idx", 64'(bus.update_idx), 64'h3);
    u0 = upd_cnt;
    hold(7'b1101111, 4'b0001, 2);
    hold(7'b1101111, 4'b0010, 2);
    hold(7'b1101111, 4'b0100, 2);
    hold(7'b1101111, 4'b1000, 2);
    check("short_no_upd", 64'(upd_cnt - u0), 64'h0);
    check("short_digits", 64'(bus.digits_bcd), 64'h4310);

    // Illegal pattern then blank
    hold(7'b1110000, 4'b1000, 3);
    check("ill_val", 64'(bus.digits_bcd[15:12]), 64'hE);
    check("ill_err", 64'(bus.digit_err[3]), 64'h1);
    hold(7'b0000000, 4'b1000, 3);
    check("blank_val", 64'(bus.digits_bcd[15:12]), 64'hF);
    check("blank_err", 64'(bus.digit_err[3]), 64'h0);

    // Illegal selects
    u0 = upd_cnt;
    hold(7'b0000110, 4'b0110, 5);
    hold(7'b0000110, 4'b0000, 5);
    check("badsel_no_upd", 64'(upd_cnt - u0), 64'h0);
    check("badsel_digits", 64'(bus.digits_bcd), 64'hF310);
    hold(7'b0000110, 4'b0100, 3);
    check("sel2_upd", 64'(bus.update), 64'h1);
    check("sel2_idx", 64'(bus.update_idx), 64'h2);
    check("sel2_digits", 64'(bus.digits_bcd), 64'hF110);

    // Reset mid-window
    hold(7'b1101101, 4'b0001, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    u0 = upd_cnt;
    hold(7'b1101101, 4'b0001, 2);
    check("rstwin_no_upd", 64'(upd_cnt - u0), 64'h0);
    hold(7'b1101101, 4'b0001, 1);
    check("rstwin_upd", 64'(bus.update), 64'h1);
    check("rstwin_digits", 64'(bus.digits_bcd), 64'hFFF5);
    check("rstwin_fv", 64'(bus.frame_valid), 64'h0);

    // Random scan traffic
    for (int it = 0; it < 2500; it++) begin
      if ($urandom_range(0, 79) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      case ($urandom_range(0, 5))
        0:       s = 7'($urandom);
        1:       s = 7'b0;
        default: s = seg_tab[$urandom_range(0, 9)];
      endcase
      if ($urandom_range(0, 4) == 0) d = N'($urandom);
      else d = N'(1) << $urandom_range(0, N - 1);
      hold(s, d, $urandom_range(1, 5));
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
